// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// piso_serializer_if : parallel-in handshake and serial-out bus for piso_serializer
// Revision: 1.0
// ============================================================================
interface piso_serializer_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;

  // master = word source / serial sink, slave = the serializer
  modport master (
    output in_data, in_valid,
    input  in_ready, sout, sout_valid, sout_first
  );
  modport slave (
    input  in_data, in_valid,
    output in_ready, sout, sout_valid, sout_first
  );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// piso_serializer : parallel-in serial-out shifter with valid/ready intake,
//                   latency 1, back-to-back frames. PISO_PARITY_EN adds an
//                   even-parity bit after each word.
// Revision: 1.0
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  piso_serializer_if.slave  bus
);

  localparam int              CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]   C_CNT_LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             r_sout, w_sout_nxt;
  logic             r_sout_valid, w_sout_valid_nxt;
  logic             r_sout_first, w_sout_first_nxt;
  logic             w_final;
  logic             w_ready;
  logic             w_accept;
`ifdef PISO_PARITY_EN
  logic             r_parity, w_parity_nxt;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? x[WIDTH-1] : x[0];
  endfunction

  // The bit just sent is dropped so the next one sits at the send position.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
  endfunction

  always_comb begin
`ifdef PISO_PARITY_EN
    w_final = (r_state == PARITY);
`else
    w_final = (r_state == SHIFT) && (r_cnt == '0);
`endif
    w_ready  = reset && ((r_state == IDLE) || w_final);
    w_accept = bus.in_valid && w_ready;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shreg_nxt      = r_shreg;
    w_sout_nxt       = 1'b0;
    w_sout_valid_nxt = 1'b0;
    w_sout_first_nxt = 1'b0;
`ifdef PISO_PARITY_EN
    w_parity_nxt     = r_parity;
`endif
    if (w_accept) begin
      w_state_nxt      = SHIFT;
      w_cnt_nxt        = C_CNT_LAST;
      w_shreg_nxt      = shift1(bus.in_data);
      w_sout_nxt       = first_bit(bus.in_data);
      w_sout_valid_nxt = 1'b1;
      w_sout_first_nxt = 1'b1;
`ifdef PISO_PARITY_EN
      w_parity_nxt     = ^bus.in_data;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (r_cnt != '0) begin
            w_cnt_nxt        = r_cnt - CW'(1);
            w_shreg_nxt      = shift1(r_shreg);
            w_sout_nxt       = first_bit(r_shreg);
            w_sout_valid_nxt = 1'b1;
          end else begin
`ifdef PISO_PARITY_EN
            w_state_nxt      = PARITY;
            w_sout_nxt       = r_parity;
            w_sout_valid_nxt = 1'b1;
`else
            w_state_nxt      = IDLE;
`endif
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_sout_first <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_sout_valid_nxt;
      r_sout_first <= w_sout_first_nxt;
`ifdef PISO_PARITY_EN
      r_parity     <= w_parity_nxt;
`endif
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.sout_first = r_sout_first;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// tb_piso_serializer : random and directed stimulus against a queue-of-bits
//                      model, for MSB-first and LSB-first instances.
// Revision: 1.0
// ============================================================================
module tb_piso_serializer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus_m ();
  piso_serializer_if #(.WIDTH(W)) bus_l ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .bus(bus_m.slave));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .bus(bus_l.slave));

  int checks = 0;
  int errors = 0;

  // Pending serial bits still to appear on sout, front = current cycle.
  bit qm[$], fm[$], ql[$], fl[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rn, input logic v, input logic [W-1:0] d);
    bit rdy_m, rdy_l;
    logic [W-1:0] dd;
    reset          = rn;
    bus_m.in_valid = v;
    bus_m.in_data  = d;
    bus_l.in_valid = v;
    bus_l.in_data  = d;
    @(negedge clk);
    rdy_m = rn && (qm.size() <= 1);
    rdy_l = rn && (ql.size() <= 1);
    chk("ready_msb", int'(bus_m.in_ready),   int'(rdy_m));
    chk("valid_msb", int'(bus_m.sout_valid), int'(qm.size() > 0));
    chk("first_msb", int'(bus_m.sout_first), qm.size() > 0 ? int'(fm[0]) : 0);
    chk("sout_msb",  int'(bus_m.sout),       qm.size() > 0 ? int'(qm[0]) : 0);
    chk("ready_lsb", int'(bus_l.in_ready),   int'(rdy_l));
    chk("valid_lsb", int'(bus_l.sout_valid), int'(ql.size() > 0));
    chk("first_lsb", int'(bus_l.sout_first), ql.size() > 0 ? int'(fl[0]) : 0);
    chk("sout_lsb",  int'(bus_l.sout),       ql.size() > 0 ? int'(ql[0]) : 0);
    @(posedge clk);
    dd = d;
    if (!rn) begin
      qm.delete(); fm.delete(); ql.delete(); fl.delete();
    end else begin
      if (qm.size() > 0) begin void'(qm.pop_front()); void'(fm.pop_front()); end
      if (ql.size() > 0) begin void'(ql.pop_front()); void'(fl.pop_front()); end
      if (v && rdy_m) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back(dd[W-1-i]); fm.push_back(i == 0);
        end
`ifdef PISO_PARITY_EN
        qm.push_back(^dd); fm.push_back(1'b0);
`endif
      end
      if (v && rdy_l) begin
        for (int i = 0; i < W; i++) begin
          ql.push_back(dd[i]); fl.push_back(i == 0);
        end
`ifdef PISO_PARITY_EN
        ql.push_back(^dd); fl.push_back(1'b0);
`endif
      end
    end
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    bus_m.in_valid = 1'b0;
    bus_m.in_data  = '0;
    bus_l.in_valid = 1'b0;
    bus_l.in_data  = '0;
    @(posedge clk);
    #1;
    // Reset state, including a word offered while reset is low.
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h9);

    // Single frame 1011 from idle.
    step(1'b1, 1'b1, 4'b1011);
    repeat (6) step(1'b1, 1'b0, 4'h0);

    // Back-to-back: A then 5 held valid until taken.
    step(1'b1, 1'b1, 4'hA);
    repeat (5) step(1'b1, 1'b1, 4'h5);
    repeat (7) step(1'b1, 1'b0, 4'h0);

    // Reset on the 2nd bit cycle of F.
    step(1'b1, 1'b1, 4'hF);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    repeat (6) step(1'b1, 1'b0, 4'h0);

    // Word offered mid-frame must be ignored.
    step(1'b1, 1'b1, 4'hC);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'h3);
    repeat (6) step(1'b1, 1'b0, 4'h0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      step(logic'($urandom_range(0, 63) != 0),
           logic'($urandom_range(0, 2) != 0),
           W'($urandom));
    end
    repeat (6) step(1'b1, 1'b0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001: Parameter WIDTH, default 4, is the parallel word width; legal range 2..16.
REQ-002: Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: reset  input  1  synchronous, active-low reset; sampled only on clk rising edge.
REQ-005: in_data  input  WIDTH  parallel word to serialize.
REQ-006: in_valid  input  1  in_data is valid.
REQ-007: in_ready  output  1  block accepts a word this cycle.
REQ-008: sout  output  1  serial data bit, registered.
REQ-009: sout_valid  output  1  sout carries a frame bit this cycle, registered.
REQ-010: sout_first  output  1  high with the first bit of each frame only, registered.

Function
REQ-011: A word is accepted on a rising edge where in_valid and in_ready are both high; in_data is captured into an internal WIDTH-bit shift register on that edge.
REQ-012: The FSM has states IDLE and SHIFT, plus PARITY when PARITY_EN is defined.
REQ-013: IDLE -> SHIFT on accept; SHIFT holds for WIDTH cycles; SHIFT -> PARITY (PARITY_EN) or IDLE after the last data bit, unless a new accept occurs.
REQ-014: A bit counter counts down from WIDTH-1 to 0 in SHIFT; the last data bit is the cycle with counter = 0.
REQ-015: The first bit appears on sout, with sout_valid = 1 and sout_first = 1, in the cycle after the accept edge (latency 1).
REQ-016: Each following cycle presents the next bit in MSB_FIRST order; sout_first = 0 for every bit except the first.
REQ-017: in_ready = 1 in IDLE, and in the final bit cycle of a frame (last data bit, or parity bit when PARITY_EN); otherwise 0.
REQ-018: An accept in the final bit cycle starts the next frame on the following cycle with no gap (back-to-back frames, sout_valid continuously high).
REQ-019: in_valid in any non-ready cycle is ignored; in_data may change freely after the accept edge without affecting the frame in flight.
REQ-020: In IDLE with no accept: sout_valid = 0, sout_first = 0, sout = 0.
REQ-021: A frame is never truncated or paused except by reset.

Reset
REQ-022: reset low at a rising edge forces state = IDLE, counter = 0, shift register = 0, sout = 0, sout_valid = 0, sout_first = 0.
REQ-023: in_ready = 0 while reset is low, and 1 in the first cycle after reset is released.
REQ-024: Reset mid-frame aborts the frame immediately; no residual bits are emitted after release.
REQ-025: Reset has priority over a simultaneous accept; that word is dropped.

Configuration
REQ-026: Macro PISO_PARITY_EN compiles in a parity stage.
REQ-027: With PISO_PARITY_EN defined: after the last data bit, one extra PARITY cycle drives sout = even parity (XOR of all WIDTH data bits), sout_valid = 1, sout_first = 0; frame length = WIDTH+1 cycles.
REQ-028: Without PISO_PARITY_EN: no PARITY state, no parity logic; frame length = WIDTH cycles.

Verification
REQ-029: WIDTH=4, MSB_FIRST=1, no parity; accept in_data=4'b1011 in IDLE -> next 4 cycles sout = 1,0,1,1; sout_valid = 1,1,1,1; sout_first = 1,0,0,0; then sout_valid = 0.
REQ-030: MSB_FIRST=0, accept 4'b1011 -> sout = 1,1,0,1.
REQ-031: Back-to-back: 4'hA accepted, in_valid held with 4'h5 -> second accept in the 4th bit cycle; sout = 1,0,1,0,0,1,0,1 with sout_valid high for 8 consecutive cycles and sout_first high on cycles 1 and 5.
REQ-032: reset driven low on the 2nd bit cycle of 4'hF -> next cycle sout_valid = 0 and in_ready = 0; after release in_ready = 1 and no further bits are emitted.
REQ-033: PISO_PARITY_EN defined, accept 4'b0111 -> sout = 0,1,1,1,1 (parity 1); in_ready high only on the 5th cycle.
REQ-034: in_valid pulsed with 4'h3 during the 2nd bit cycle of an active frame -> word ignored; output stream unchanged.
